wta_gamma_controller: RTL and testbench
=======================================

WTA_GAMMA_CONTROLLER -- requirements
Module: wta_gamma_controller

Interface
REQ-001 Parameter NEURONS, default 8, number of columns in the layer competing for one winner.
REQ-002 Parameter TIME_PERIOD, default 16, cycles per gamma window; TW = $clog2(TIME_PERIOD), NW = $clog2(NEURONS).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; high = run gamma windows back-to-back.
REQ-006 spike_volley  input  NEURONS  per-cycle spike flags from the neuron columns.
REQ-007 res_ready  input  1  downstream accepts result.
REQ-008 gamma_start  output  1  one-cycle pulse at time 0 of every window; clears neuron potentials.
REQ-009 gamma_time  output  TW  current time step within the window.
REQ-010 inhibit  output  1  high once a winner is latched; gates all other columns.
REQ-011 busy  output  1  high in RUN or REPORT.
REQ-012 res_valid  output  1  result available.
REQ-013 res_neuron  output  NW  winning column index.
REQ-014 res_time  output  TW  time step at which the winner spiked.
REQ-015 res_nowin  output  1  result carries no winner (only with INHIB_NOWIN_REPORT_EN).

Function
REQ-016 FSM states SHALL be IDLE, RUN, REPORT.
REQ-017 IDLE -> RUN when enable=1; on entry gamma_time=0, gamma_start=1 for that cycle, winner flag and inhibit cleared.
REQ-018 In RUN, gamma_time SHALL increment by 1 per cycle; spike_volley is evaluated every RUN cycle, including gamma_time=TIME_PERIOD-1.
REQ-019 First RUN cycle with spike_volley!=0 and no winner latched: latch winner = lowest set index, win time = gamma_time; inhibit=1 from the next cycle.
REQ-020 Simultaneous spikes SHALL resolve to the lowest index; spikes after a winner is latched SHALL be ignored.
REQ-021 At gamma_time=TIME_PERIOD-1, RUN -> REPORT if a winner is latched; otherwise per REQ-030/031.
REQ-022 In REPORT, res_valid=1 with res_neuron/res_time/res_nowin stable until the cycle res_ready=1.
REQ-023 On res_valid&&res_ready: go to RUN (new window, REQ-017 actions) if enable=1, else IDLE; res_valid low next cycle.
REQ-024 inhibit SHALL remain high from latch through REPORT and clear only on the next window start or IDLE entry.
REQ-025 enable deasserted mid-window SHALL NOT abort the window; it only prevents the next window.
REQ-026 gamma_time SHALL wrap to 0 only via a new window start; it holds its last value in REPORT and reads 0 in IDLE.
REQ-027 busy SHALL be 1 in RUN and REPORT, 0 in IDLE.
REQ-028 res_neuron, res_time SHALL hold last reported values when res_valid=0.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, gamma_time=0, gamma_start=0, inhibit=0, busy=0, res_valid=0, res_neuron=0, res_time=0, res_nowin=0, winner flag cleared, including mid-window or mid-REPORT.

Configuration
REQ-030 With macro INHIB_NOWIN_REPORT_EN defined: a window ending with no winner SHALL enter REPORT with res_nowin=1, res_neuron=0, res_time=TIME_PERIOD-1.
REQ-031 Without INHIB_NOWIN_REPORT_EN: a window with no winner SHALL produce no result and go directly to RUN (new window) if enable=1, else IDLE; res_nowin tied 0.

Verification
REQ-032 enable=1, spike_volley=8'b0010_0000 at gamma_time=3 only, res_ready=1 -> inhibit high from time 4, res_valid after time 15 with res_neuron=5, res_time=3.
REQ-033 spike_volley=8'b1001_0100 at gamma_time=0 -> res_neuron=2, res_time=0; later spike on neuron 0 at time 7 ignored.
REQ-034 Winner at time 2, res_ready=0 for 5 cycles in REPORT -> res_valid and outputs stable all 5 cycles; next window's gamma_start the cycle after acceptance.
REQ-035 No spikes for whole window -> with INHIB_NOWIN_REPORT_EN res_valid=1, res_nowin=1, res_time=15; without it no res_valid and gamma_start 16 cycles after previous.
REQ-036 rst_n pulsed low at gamma_time=9 after a winner at time 4 -> all outputs 0 immediately, IDLE; with enable=1 new window starts gamma_time=0 after release.
REQ-037 enable dropped at gamma_time=6 -> window completes, one result reported, then IDLE with busy=0.

Source files
------------

// File: rtl/wta_gamma_controller_if.sv
// ---------------------------------------------------------------------------
// wta_gamma_controller_if
//   Bundles the enable/spike inputs, the gamma-window timing outputs and the
//   result handshake of the winner-take-all gamma controller.
//
//   master modport : the controller (drives timing, inhibit and result)
//   slave modport  : the neuron layer / result consumer
//
//   enable        level, run gamma windows back-to-back while high
//   spike_volley  per-cycle spike flags, one per neuron column
//   res_ready     consumer accepts the presented result
//   gamma_start   one-cycle pulse at time 0 of every window
//   gamma_time    time step within the current window
//   inhibit       high once a winner is latched
//   busy          controller is inside a window or holding a result
//   res_valid     result available
//   res_neuron    winning column index
//   res_time      time step at which the winner spiked
//   res_nowin     result carries no winner
// ---------------------------------------------------------------------------
interface wta_gamma_controller_if #(
    parameter int NEURONS     = 8,
    parameter int TIME_PERIOD = 16
);
    localparam int TW = $clog2(TIME_PERIOD);
    localparam int NW = $clog2(NEURONS);

    logic               enable;
    logic [NEURONS-1:0] spike_volley;
    logic               res_ready;
    logic               gamma_start;
    logic [TW-1:0]      gamma_time;
    logic               inhibit;
    logic               busy;
    logic               res_valid;
    logic [NW-1:0]      res_neuron;
    logic [TW-1:0]      res_time;
    logic               res_nowin;

    modport master (
        input  enable, spike_volley, res_ready,
        output gamma_start, gamma_time, inhibit, busy,
               res_valid, res_neuron, res_time, res_nowin
    );

    modport slave (
        output enable, spike_volley, res_ready,
        input  gamma_start, gamma_time, inhibit, busy,
               res_valid, res_neuron, res_time, res_nowin
    );
endinterface

// File: rtl/wta_gamma_controller.sv
// ---------------------------------------------------------------------------
// wta_gamma_controller
//   Runs fixed-length gamma windows over a layer of neuron columns and picks
//   the first column to spike (lowest index on ties) as the winner. Once a
//   winner is latched, inhibit gates all other columns until the next window.
//   At the end of a window with a winner, the result is held on the result
//   handshake until the consumer accepts it.
//
//   Ports:
//     clk    sole clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    wta_gamma_controller_if.master (see interface for signal list)
//
//   Configuration macro:
//     INHIB_NOWIN_REPORT_EN  when defined, a window without any spike still
//                            produces a result with res_nowin=1, res_neuron=0,
//                            res_time=TIME_PERIOD-1. When undefined such a
//                            window produces no result and res_nowin is 0.
// ---------------------------------------------------------------------------
module wta_gamma_controller #(
    parameter int NEURONS     = 8,
    parameter int TIME_PERIOD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    wta_gamma_controller_if.master  bus
);
    localparam int TW = $clog2(TIME_PERIOD);
    localparam int NW = $clog2(NEURONS);
    localparam logic [TW-1:0] LAST_TIME = TW'(TIME_PERIOD - 1);

`ifdef INHIB_NOWIN_REPORT_EN
    localparam bit NOWIN_REPORT = 1'b1;
`else
    localparam bit NOWIN_REPORT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] gamma_time_q;
    logic          gamma_start_q;
    logic          win_flag_q;
    logic [NW-1:0] win_neuron_q;
    logic [TW-1:0] win_time_q;
    logic          res_valid_q;
    logic [NW-1:0] res_neuron_q;
    logic [TW-1:0] res_time_q;

    logic [NW-1:0] low_idx;
    logic          window_end;
    logic          spike_hit;
    logic          win_now;
    logic          report_go;
    logic          accept;
    logic          start_window;
    logic          go_idle;

    // Priority encoder: scanning from the top down lets the lowest set
    // index overwrite any higher one, so simultaneous spikes resolve low.
    always_comb begin
        low_idx = '0;
        for (int i = NEURONS - 1; i >= 0; i--) begin
            if (bus.spike_volley[i]) begin
                low_idx = NW'(i);
            end
        end
    end

    // Window bookkeeping. A spike on the last time step still counts, so the
    // winner decision at window end looks at both the latched flag and the
    // spike arriving in that same cycle.
    always_comb begin
        window_end   = (state_q == RUN) && (gamma_time_q == LAST_TIME);
        spike_hit    = (state_q == RUN) && !win_flag_q && (|bus.spike_volley);
        win_now      = win_flag_q || spike_hit;
        report_go    = window_end && (win_now || NOWIN_REPORT);
        accept       = (state_q == REPORT) && bus.res_ready;
        start_window = bus.enable &&
                       (((state_q == IDLE)) ||
                        (window_end && !report_go) ||
                        accept);
        go_idle      = !bus.enable && ((window_end && !report_go) || accept);
    end

    always_comb begin
        state_d = state_q;
        if (start_window) begin
            state_d = RUN;
        end else if (go_idle) begin
            state_d = IDLE;
        end else if (report_go) begin
            state_d = REPORT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Time base: restarts only at a window start, freezes on the last step
    // while a result is held, and parks at zero in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gamma_time_q  <= '0;
            gamma_start_q <= 1'b0;
        end else begin
            gamma_start_q <= start_window;
            if (start_window || go_idle) begin
                gamma_time_q <= '0;
            end else if ((state_q == RUN) && !window_end) begin
                gamma_time_q <= gamma_time_q + TW'(1);
            end
        end
    end

    // Winner latch. The flag doubles as the inhibit output, so inhibit rises
    // the cycle after the winning spike and falls only when a new window
    // starts or the controller returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_flag_q   <= 1'b0;
            win_neuron_q <= '0;
            win_time_q   <= '0;
        end else begin
            if (start_window || go_idle) begin
                win_flag_q <= 1'b0;
            end else if (spike_hit) begin
                win_flag_q   <= 1'b1;
                win_neuron_q <= low_idx;
                win_time_q   <= gamma_time_q;
            end
        end
    end

    // Result registers are loaded only on REPORT entry, so they keep the
    // last reported values after the handshake completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            res_neuron_q <= '0;
            res_time_q   <= '0;
        end else begin
            if (report_go) begin
                res_valid_q <= 1'b1;
                if (spike_hit) begin
                    res_neuron_q <= low_idx;
                    res_time_q   <= gamma_time_q;
                end else if (win_flag_q) begin
                    res_neuron_q <= win_neuron_q;
                    res_time_q   <= win_time_q;
                end else begin
                    res_neuron_q <= '0;
                    res_time_q   <= LAST_TIME;
                end
            end else if (accept) begin
                res_valid_q <= 1'b0;
            end
        end
    end

`ifdef INHIB_NOWIN_REPORT_EN
    logic res_nowin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_nowin_q <= 1'b0;
        end else if (report_go) begin
            res_nowin_q <= !win_now;
        end
    end

    assign bus.res_nowin = res_nowin_q;
`else
    assign bus.res_nowin = 1'b0;
`endif

    assign bus.gamma_start = gamma_start_q;
    assign bus.gamma_time  = gamma_time_q;
    assign bus.inhibit     = win_flag_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.res_valid   = res_valid_q;
    assign bus.res_neuron  = res_neuron_q;
    assign bus.res_time    = res_time_q;
endmodule

// File: tb/tb_wta_gamma_controller.sv
// ---------------------------------------------------------------------------
// tb_wta_gamma_controller
//   Directed-vector bench for wta_gamma_controller (NEURONS=8,
//   TIME_PERIOD=16). Each window's expected result is queued when its
//   stimulus is issued; a monitor pops and compares on every accepted
//   result. Window timing, inhibit, busy, stall and reset behaviour are
//   checked inline by the stimulus process.
// ---------------------------------------------------------------------------
module tb_wta_gamma_controller;
    logic clk;
    logic rst_n;

    typedef struct {
        int n;
        int t;
        int nowin;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

    wta_gamma_controller_if #(.NEURONS(8), .TIME_PERIOD(16)) bus ();

    wta_gamma_controller #(.NEURONS(8), .TIME_PERIOD(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one full window starting with gamma_time=0 visible. Spike
    // vector va is applied at time ta and vb at tb (-1 = unused); enable is
    // dropped at time drop_at. The expected result is queued up front.
    task automatic applyStimulus(input int ta, input logic [7:0] va,
                                 input int tb, input logic [7:0] vb,
                                 input int drop_at, input bit exp_win,
                                 input int exp_n, input int exp_t);
        exp_t e;
        if (exp_win) begin
            e.n = exp_n; e.t = exp_t; e.nowin = 0;
            exp_q.push_back(e);
        end
`ifdef INHIB_NOWIN_REPORT_EN
        else begin
            e.n = 0; e.t = 15; e.nowin = 1;
            exp_q.push_back(e);
        end
`endif
        for (int t = 0; t < 16; t++) begin
            checkOutput("gamma_time", int'(bus.gamma_time), t);
            checkOutput("gamma_start", int'(bus.gamma_start), (t == 0) ? 1 : 0);
            checkOutput("inhibit", int'(bus.inhibit), (exp_win && t > exp_t) ? 1 : 0);
            checkOutput("busy", int'(bus.busy), 1);
            if (t == ta)      bus.spike_volley = va;
            else if (t == tb) bus.spike_volley = vb;
            else              bus.spike_volley = 8'h00;
            if (t == drop_at) bus.enable = 1'b0;
            step();
        end
        bus.spike_volley = 8'h00;
    endtask

    // Scoreboard monitor: compares each accepted result with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_result: got neuron %0d time %0d, none expected",
                             bus.res_neuron, bus.res_time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("res_neuron", int'(bus.res_neuron), e.n);
                    checkOutput("res_time", int'(bus.res_time), e.t);
                    checkOutput("res_nowin", int'(bus.res_nowin), e.nowin);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.enable       = 1'b0;
        bus.spike_volley = 8'h00;
        bus.res_ready    = 1'b0;
        repeat (3) step();

        checkOutput("rst_gamma_time", int'(bus.gamma_time), 0);
        checkOutput("rst_gamma_start", int'(bus.gamma_start), 0);
        checkOutput("rst_inhibit", int'(bus.inhibit), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_res_valid", int'(bus.res_valid), 0);
        checkOutput("rst_res_neuron", int'(bus.res_neuron), 0);
        checkOutput("rst_res_time", int'(bus.res_time), 0);
        checkOutput("rst_res_nowin", int'(bus.res_nowin), 0);

        rst_n = 1'b1;
        step();
        checkOutput("idle_busy", int'(bus.busy), 0);

        // Single spike on neuron 5 at time 3.
        bus.enable    = 1'b1;
        bus.res_ready = 1'b1;
        step();
        applyStimulus(3, 8'b0010_0000, -1, 8'h00, -1, 1'b1, 5, 3);
        checkOutput("t1_res_valid", int'(bus.res_valid), 1);
        checkOutput("t1_hold_time", int'(bus.gamma_time), 15);
        checkOutput("t1_inhibit", int'(bus.inhibit), 1);
        checkOutput("t1_busy", int'(bus.busy), 1);
        step();
        checkOutput("t1_valid_low", int'(bus.res_valid), 0);
        checkOutput("t1_neuron_hold", int'(bus.res_neuron), 5);
        checkOutput("t1_time_hold", int'(bus.res_time), 3);

        // Simultaneous spikes at time 0 resolve low; later neuron 0 ignored.
        applyStimulus(0, 8'b1001_0100, 7, 8'b0000_0001, -1, 1'b1, 2, 0);
        checkOutput("t2_res_valid", int'(bus.res_valid), 1);
        step();

        // Winner at time 2 with the consumer stalling for five cycles.
        bus.res_ready = 1'b0;
        applyStimulus(2, 8'b0000_1000, -1, 8'h00, -1, 1'b1, 3, 2);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_stall_valid", int'(bus.res_valid), 1);
            checkOutput("t3_stall_neuron", int'(bus.res_neuron), 3);
            checkOutput("t3_stall_time", int'(bus.res_time), 2);
            checkOutput("t3_stall_start", int'(bus.gamma_start), 0);
            step();
        end
        bus.res_ready = 1'b1;
        step();
        checkOutput("t3_next_start", int'(bus.gamma_start), 1);
        checkOutput("t3_valid_low", int'(bus.res_valid), 0);

        // Window with no spikes at all.
        applyStimulus(-1, 8'h00, -1, 8'h00, -1, 1'b0, 0, 0);
`ifdef INHIB_NOWIN_REPORT_EN
        checkOutput("t4_res_valid", int'(bus.res_valid), 1);
        checkOutput("t4_res_nowin", int'(bus.res_nowin), 1);
        checkOutput("t4_res_time", int'(bus.res_time), 15);
        checkOutput("t4_res_neuron", int'(bus.res_neuron), 0);
        step();
`else
        checkOutput("t4_res_valid", int'(bus.res_valid), 0);
        checkOutput("t4_restart", int'(bus.gamma_start), 1);
`endif

        // Spike on the final time step still wins.
        applyStimulus(15, 8'b1000_0000, -1, 8'h00, -1, 1'b1, 7, 15);
        checkOutput("t5_res_valid", int'(bus.res_valid), 1);
        checkOutput("t5_inhibit", int'(bus.inhibit), 1);
        step();

        // Enable dropped mid-window: window completes, then IDLE.
        applyStimulus(1, 8'b0100_0000, -1, 8'h00, 6, 1'b1, 6, 1);
        checkOutput("t6_res_valid", int'(bus.res_valid), 1);
        step();
        checkOutput("t6_idle_busy", int'(bus.busy), 0);
        checkOutput("t6_idle_time", int'(bus.gamma_time), 0);
        checkOutput("t6_idle_inhibit", int'(bus.inhibit), 0);
        checkOutput("t6_idle_valid", int'(bus.res_valid), 0);
        step();
        checkOutput("t6_idle_start", int'(bus.gamma_start), 0);
        checkOutput("t6_idle_busy2", int'(bus.busy), 0);

        // Reset pulsed at time 9 after a winner at time 4.
        bus.enable = 1'b1;
        step();
        for (int t = 0; t < 9; t++) begin
            bus.spike_volley = (t == 4) ? 8'b0000_0010 : 8'h00;
            step();
        end
        bus.spike_volley = 8'h00;
        checkOutput("t7_time9", int'(bus.gamma_time), 9);
        checkOutput("t7_inhibit", int'(bus.inhibit), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t7_rst_time", int'(bus.gamma_time), 0);
        checkOutput("t7_rst_inhibit", int'(bus.inhibit), 0);
        checkOutput("t7_rst_busy", int'(bus.busy), 0);
        checkOutput("t7_rst_valid", int'(bus.res_valid), 0);
        checkOutput("t7_rst_neuron", int'(bus.res_neuron), 0);
        checkOutput("t7_rst_restime", int'(bus.res_time), 0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("t7_restart_start", int'(bus.gamma_start), 1);
        checkOutput("t7_restart_time", int'(bus.gamma_time), 0);
        checkOutput("t7_restart_busy", int'(bus.busy), 1);

        bus.enable = 1'b0;
        repeat (2) step();
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
